// File: rtl/led_pkg.sv
// Shared definitions for the LED event stretcher: state encoding and the
// helper that sizes the per-state tick counter.
package led_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    ON   = 2'b01,
    GAP  = 2'b10
  } state_t;

  // Tick counter width: enough bits for the longer of the ON and GAP phases,
  // never less than one bit.
  function automatic int tick_cnt_width(input int on_ticks, input int off_ticks);
    int longest;
    longest = (on_ticks > off_ticks) ? on_ticks : off_ticks;
    return ($clog2(longest) < 1) ? 1 : $clog2(longest);
  endfunction

endpackage

// File: rtl/tick_prescaler.sv
// Free-running divide-by-TICK_DIV counter that produces a one-cycle tick
// enable. The synchronous clear lets the owner restart the phase exactly.
module tick_prescaler #(
  parameter int TICK_DIV = 100
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  output logic tick
);

  localparam int DIV_W = $clog2(TICK_DIV);

  logic [DIV_W-1:0] count;

  assign tick = (count == DIV_W'(TICK_DIV - 1));

  // Count 0..TICK_DIV-1 and wrap; a clear restarts the count from zero.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count <= '0;
    end else if (clr || tick) begin
      count <= '0;
    end else begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/led_event_stretcher.sv
// Stretches single-cycle event pulses into fixed-length LED blinks separated
// by an enforced dark gap. Events arriving mid-blink are queued in a
// saturating counter and replayed one blink at a time.
module led_event_stretcher
  import led_pkg::*;
#(
  parameter int TICK_DIV  = 100,
  parameter int ON_TICKS  = 50,
  parameter int OFF_TICKS = 25,
  parameter int PEND_W    = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_event,
  output logic              o_led,
  output logic              o_busy,
  output logic [PEND_W-1:0] o_pending,
  output logic              o_overflow
);

  localparam int              CNT_W    = tick_cnt_width(ON_TICKS, OFF_TICKS);
  localparam logic [PEND_W-1:0] PEND_MAX = {PEND_W{1'b1}};

  state_t           state;
  state_t           next_state;
  logic [CNT_W-1:0] tick_cnt;
  logic             tick;
  logic             state_change;
  logic             take_queued;
  logic             take_live;
  logic             queue_inc;
  logic             overflow;

  // The prescaler is held clear in IDLE and restarted on every state entry,
  // so each ON and GAP phase lasts an exact multiple of TICK_DIV cycles.
  tick_prescaler #(
    .TICK_DIV(TICK_DIV)
  ) u_prescaler (
    .clk (clk),
    .rst (rst),
    .clr (state_change || (state == IDLE)),
    .tick(tick)
  );

  // Next-state decision and which event source (queue or live pulse) feeds
  // the next blink. The queue has priority so replay order is preserved.
  always_comb begin
    next_state  = state;
    take_queued = 1'b0;
    take_live   = 1'b0;
    case (state)
      IDLE: begin
        if (i_event) begin
          next_state = ON;
          take_live  = 1'b1;
        end else if (o_pending != '0) begin
          next_state  = ON;
          take_queued = 1'b1;
        end
      end
      ON: begin
        if (tick && (tick_cnt == CNT_W'(ON_TICKS - 1))) begin
          next_state = GAP;
        end
      end
      GAP: begin
        if (tick && (tick_cnt == CNT_W'(OFF_TICKS - 1))) begin
          if (o_pending != '0) begin
            next_state  = ON;
            take_queued = 1'b1;
          end else if (i_event) begin
            next_state = ON;
            take_live  = 1'b1;
          end else begin
            next_state = IDLE;
          end
        end
      end
      default: next_state = IDLE;
    endcase
  end

  assign state_change = (next_state != state);
  assign queue_inc    = i_event && !take_live;
  assign overflow     = queue_inc && !take_queued && (o_pending == PEND_MAX);

  // State register with LED and busy driven from the next state so they line
  // up exactly with the state they describe.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= IDLE;
      o_led  <= 1'b0;
      o_busy <= 1'b0;
    end else begin
      state  <= next_state;
      o_led  <= (next_state == ON);
      o_busy <= (next_state != IDLE);
    end
  end

  // Ticks elapsed in the current phase; restarts on every state entry.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tick_cnt <= '0;
    end else if (state_change) begin
      tick_cnt <= '0;
    end else if (tick) begin
      tick_cnt <= tick_cnt + 1'b1;
    end
  end

  // Saturating pending queue; a simultaneous push and pop cancel out and
  // never count as an overflow.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      o_pending  <= '0;
      o_overflow <= 1'b0;
    end else begin
      o_overflow <= overflow;
      case ({queue_inc, take_queued})
        2'b10: begin
          if (o_pending != PEND_MAX) begin
            o_pending <= o_pending + 1'b1;
          end
        end
        2'b01:   o_pending <= o_pending - 1'b1;
        default: o_pending <= o_pending;
      endcase
    end
  end

endmodule

// File: doc/led_event_stretcher.md
# led_event_stretcher

Output-side counterpart to the button input path. It takes single-cycle event pulses from a debouncer, SPI/I2C status logic or a register write, and stretches each one into a human-visible LED blink of fixed length. A minimum dark gap follows each blink, so back-to-back events show as separate blinks. Events that arrive during a blink are queued in a saturating counter and replayed in order. The block sits between control logic and a board LED pin.

## Interface
- TICK_DIV, 100: clk cycles per tick; must be ≥ 2.
- ON_TICKS, 50: ticks the LED is lit per blink; must be ≥ 1.
- OFF_TICKS, 25: dark ticks enforced after each blink; must be ≥ 1.
- PEND_W, 3: pending-counter width; saturates at 2^PEND_W−1.
- clk  in  1  system clock; the only clock in the block.
- rst  in  1  reset, asynchronous, active-low (rst=0 resets).
- i_event  in  1  one-cycle event pulse; must be synchronous to clk.
- o_led  out  1  registered LED drive, 1 = lit.
- o_busy  out  1  1 whenever the state is not IDLE.
- o_pending  out  PEND_W  number of queued events not yet blinked.
- o_overflow  out  1  one-cycle pulse when an event is dropped because the queue is saturated.

## Operation
- State machine states: IDLE, ON, GAP.
- IDLE:
  - i_event=1 → ON on the next edge.
  - o_pending>0 → ON, and o_pending decrements by 1.
  - Otherwise stay in IDLE.
- ON:
  - o_led=1.
  - After ON_TICKS ticks → GAP.
- GAP:
  - o_led=0.
  - After OFF_TICKS ticks, go to ON if an event is available, otherwise to IDLE.
  - An event is available if o_pending>0 (consume one from the queue) or i_event=1 on that cycle (consume the live event).
- Queueing:
  - i_event=1 in ON or GAP increments o_pending, unless the event is consumed directly as described above.
  - At saturation the event is dropped and o_overflow=1 for one cycle.
- Simultaneous increment and decrement on one cycle: o_pending is unchanged and o_overflow stays 0, even at saturation.
- Tick generation:
  - The prescaler counts 0..TICK_DIV−1 and strobes a tick on the count of TICK_DIV−1.
  - The tick is a clock enable, not a derived clock. All logic is clocked by clk.
  - The prescaler and the tick counter clear on every state entry, so phase is exact.
- Widths:
  - Prescaler is $clog2(TICK_DIV) bits.
  - Tick counter is $clog2(max(ON_TICKS,OFF_TICKS)) bits, minimum 1.
  - o_pending never wraps.

## Timing
- Reset values:
  - Outputs: o_led=0, o_busy=0, o_pending=0, o_overflow=0.
  - Internal: state=IDLE, all counters 0.
  - Reset takes effect immediately, including in the middle of a blink, and any queued events are discarded.
- Latency: i_event in IDLE on cycle k → o_led=1 and o_busy=1 from cycle k+1.
- Blink length: o_led stays high for exactly ON_TICKS·TICK_DIV cycles.
- Gap length: GAP lasts exactly OFF_TICKS·TICK_DIV cycles.
- GAP→ON with an event available: no IDLE cycle in between. o_led rises on the cycle after the last GAP cycle.
- GAP→IDLE: o_busy falls on the first IDLE cycle.
- o_pending and o_overflow are registered and update on the edge after the event.

## Structure
- Shared package led_pkg holds:
  - The state encoding: IDLE=2'b00, ON=2'b01, GAP=2'b10.
  - The helper constant for the tick-counter width.
- One sub-module, tick_prescaler, with ports clk, rst, clr in, tick out.
  - It is a free-running counter with a synchronous clear.
  - Only a single instance is used.
- The top level holds the FSM, tick counter and pending counter.

## Test plan
Parameters for all scenarios: TICK_DIV=4, ON_TICKS=3, OFF_TICKS=2, PEND_W=2. This gives ON = 12 cycles and GAP = 8 cycles.
- Single event:
  - Stimulus: i_event on cycle k in IDLE.
  - Required: o_led=1 on cycles k+1..k+12 and 0 on k+13..k+20; o_busy=1 on k+1..k+20 and 0 from k+21.
- Queueing:
  - Stimulus: 3 events during ON.
  - Required: o_pending reaches 3, then 4 blinks in total; o_pending steps 3→2→1→0 at each GAP→ON transition.
- Saturation:
  - Stimulus: 5 events during ON.
  - Required: o_pending=3 and exactly 2 o_overflow pulses.
- Simultaneous increment and decrement:
  - Stimulus: o_pending=3, i_event on the last GAP cycle.
  - Required: o_pending stays 3, no o_overflow, next blink starts immediately.
- Live event at end of GAP:
  - Stimulus: o_pending=0, i_event on the last GAP cycle.
  - Required: straight to ON with no IDLE cycle, and o_pending stays 0.
- Mid-blink reset:
  - Stimulus: rst=0 at cycle 5 of ON with o_pending=2.
  - Required: o_led, o_busy and o_pending go to 0 asynchronously; after release, no blink occurs without a new event.
